// File: rtl/cpu_control_fsm.sv
// Multicycle fetch/decode/execute controller for a 16-bit core sitting in front of an 8x16 register file.
// Each instruction is FETCH, DECODE, EXEC; ld adds a LDWB cycle to write back the memory read data.
module cpu_control_fsm #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [15:0] o_mem_wrdata,
    input  logic [15:0] i_mem_rddata,
    output logic        o_rf_write,
    output logic [2:0]  o_rf_addrw,
    output logic [2:0]  o_rf_addrx,
    output logic [2:0]  o_rf_addry,
    output logic [15:0] o_rf_data_in,
    input  logic [15:0] i_rf_datax,
    input  logic [15:0] i_rf_datay,
    output logic [15:0] o_pc,
    output logic [1:0]  o_flags
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_LDWB} state_t;

    localparam logic [3:0] OP_MV = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_CMP = 4'd3,
                           OP_LD = 4'd4, OP_ST = 4'd5, OP_MVHI = 4'd6, OP_J = 4'd8,
                           OP_JZ = 4'd9, OP_JN = 4'd10, OP_CALL = 4'd12;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [1:0]  r_flags;   // {N,Z}

    logic [3:0]  w_op;
    logic        w_imm;
    logic [15:0] w_op2;
    logic [15:0] w_alu;
    logic [15:0] w_target;
    logic        w_taken;
    logic        w_sets_flags;

    assign w_op   = r_ir[3:0];
    assign w_imm  = r_ir[4];
    assign w_op2  = w_imm ? {{8{r_ir[15]}}, r_ir[15:8]} : i_rf_datay;
    assign w_alu  = (w_op == OP_ADD) ? i_rf_datax + w_op2 : i_rf_datax - w_op2;
    // Branch offset is 2*imm11 relative to the already-incremented PC
    assign w_target = w_imm ? r_pc + {{4{r_ir[15]}}, r_ir[15:5], 1'b0} : i_rf_datax;
    assign w_sets_flags = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_CMP);

    always_comb begin
        w_taken = 1'b0;
        case (w_op)
            OP_J, OP_CALL: w_taken = 1'b1;
            OP_JZ:         w_taken = r_flags[0];
            OP_JN:         w_taken = r_flags[1];
            default:       w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= 16'h0000;
            r_flags <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE:   r_state <= S_FETCH;
                S_FETCH: begin
                    r_pc    <= r_pc + 16'd2;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_ir    <= i_mem_rddata;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_sets_flags)
                        r_flags <= {w_alu[15], (w_alu == 16'h0000)};
                    if (w_taken)
                        r_pc <= w_target;
                    r_state <= (w_op == OP_LD) ? S_LDWB : S_FETCH;
                end
                S_LDWB:   r_state <= S_FETCH;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode from state: regfile reads and ld return data only exist within the cycle
    always_comb begin
        o_mem_addr   = 16'h0000;
        o_mem_rd     = 1'b0;
        o_mem_wr     = 1'b0;
        o_mem_wrdata = 16'h0000;
        o_rf_write   = 1'b0;
        o_rf_addrw   = 3'd0;
        o_rf_data_in = 16'h0000;
        case (r_state)
            S_FETCH: begin
                o_mem_addr = r_pc;
                o_mem_rd   = 1'b1;
            end
            S_EXEC: begin
                o_rf_addrw = r_ir[7:5];
                case (w_op)
                    OP_MV: begin
                        o_rf_write   = 1'b1;
                        o_rf_data_in = w_op2;
                    end
                    OP_ADD, OP_SUB: begin
                        o_rf_write   = 1'b1;
                        o_rf_data_in = w_alu;
                    end
                    OP_MVHI: begin
                        o_rf_write   = 1'b1;
                        o_rf_data_in = {r_ir[15:8], i_rf_datax[7:0]};
                    end
                    OP_CALL: begin
                        o_rf_write   = 1'b1;
                        o_rf_addrw   = 3'd7;
                        o_rf_data_in = r_pc;
                    end
                    OP_LD: begin
                        o_mem_rd   = 1'b1;
                        o_mem_addr = i_rf_datay;
                    end
                    OP_ST: begin
                        o_mem_wr     = 1'b1;
                        o_mem_addr   = i_rf_datay;
                        o_mem_wrdata = i_rf_datax;
                    end
                    default: ;
                endcase
            end
            S_LDWB: begin
                o_rf_write   = 1'b1;
                o_rf_addrw   = r_ir[7:5];
                o_rf_data_in = i_mem_rddata;
            end
            default: ;
        endcase
    end

    assign o_rf_addrx = r_ir[7:5];
    assign o_rf_addry = r_ir[10:8];
    assign o_pc       = r_pc;
    assign o_flags    = r_flags;
endmodule
